// File: rtl/discr_scaler_reader.sv
// discr_scaler_reader: captures discriminator scaler period results into a small FIFO.
// Each entry is tagged with a sequence number and a saturation flag. Software reads it
// through a request/acknowledge port.
// Optional build macro DISCR_SCALER_RD_TIMESTAMP_EN adds a 32-bit cycle timestamp
// in the MSBs of every entry.

module discr_scaler_reader #(
    parameter int unsigned P_N_WIDTH    = 16,
    parameter int unsigned P_ADDR_WIDTH = 4,
    parameter int unsigned P_SEQ_WIDTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_update,
    input  logic [P_N_WIDTH-1:0]                  in_count,
    input  logic                                  in_valid,
    input  logic                                  flush,
    input  logic                                  rd_req,
    output logic                                  rd_ack,
`ifdef DISCR_SCALER_RD_TIMESTAMP_EN
    output logic [32+P_SEQ_WIDTH+P_N_WIDTH:0]     rd_data,
`else
    output logic [P_SEQ_WIDTH+P_N_WIDTH:0]        rd_data,
`endif
    output logic                                  rd_err,
    output logic [P_ADDR_WIDTH:0]                 fill,
    output logic [15:0]                           drop_cnt
);

    localparam int unsigned DEPTH = 1 << P_ADDR_WIDTH;
`ifdef DISCR_SCALER_RD_TIMESTAMP_EN
    localparam int unsigned EW = 32 + P_SEQ_WIDTH + 1 + P_N_WIDTH;
`else
    localparam int unsigned EW = P_SEQ_WIDTH + 1 + P_N_WIDTH;
`endif

    logic [EW-1:0]           mem [DEPTH];
    logic [P_ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
    logic [P_SEQ_WIDTH-1:0]  seq_q;
    logic [15:0]             drop_cnt_q;
    logic                    rd_ack_q, rd_err_q;
    logic [EW-1:0]           rd_data_q;

    logic                    empty, full;
    logic                    pop, push, drop;
    logic [EW-1:0]           entry;

`ifdef DISCR_SCALER_RD_TIMESTAMP_EN
    logic [31:0]             ts_q;

    // Free-running cycle counter, wraps naturally at 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign entry = {ts_q, seq_q, ~in_valid, in_count};
`else
    assign entry = {seq_q, ~in_valid, in_count};
`endif

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[P_ADDR_WIDTH] != rd_ptr_q[P_ADDR_WIDTH]) &&
                   (wr_ptr_q[P_ADDR_WIDTH-1:0] == rd_ptr_q[P_ADDR_WIDTH-1:0]);

    // Flush wins over everything; a pop at full frees the slot for a same-cycle write.
    always_comb begin
        pop  = rd_req && !empty && !flush;
        push = in_update && !flush && (!full || pop);
        drop = in_update && !flush && full && !pop;
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[P_ADDR_WIDTH-1:0]] <= entry;
        end
    end

    // Pointer management; flush clears both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Sequence number advances on every update, even dropped or flushed ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (in_update) begin
            seq_q <= seq_q + 1'b1;
        end
    end

    // Saturating count of updates lost to a full FIFO; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    // Read response: every request is acked next cycle; empty or flushed requests error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_req;
            rd_err_q <= rd_req && !pop;
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q[P_ADDR_WIDTH-1:0]];
            end else if (rd_req) begin
                rd_data_q <= '0;
            end
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_data_q;
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_discr_scaler_reader.sv
// Scoreboard bench for discr_scaler_reader with a 4-bit count and a 4-entry FIFO.
// Expected read responses are queued by the stimulus and checked by a monitor on each ack.

module tb_discr_scaler_reader;

    localparam int unsigned NW = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned SW = 8;
    localparam int unsigned W  = SW + 1 + NW;
`ifdef DISCR_SCALER_RD_TIMESTAMP_EN
    localparam int unsigned DW = W + 32;
`else
    localparam int unsigned DW = W;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_update;
    logic [NW-1:0] in_count;
    logic          in_valid;
    logic          flush;
    logic          rd_req;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic [AW:0]   fill;
    logic [15:0]   drop_cnt;

    logic [W:0]    exp_q [$];
    logic [31:0]   ts_log [$];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    discr_scaler_reader #(
        .P_N_WIDTH    (NW),
        .P_ADDR_WIDTH (AW),
        .P_SEQ_WIDTH  (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_update (in_update),
        .in_count  (in_count),
        .in_valid  (in_valid),
        .flush     (flush),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .fill      (fill),
        .drop_cnt  (drop_cnt)
    );

    // Monitor: each ack pops one expected {err, data} and compares.
    always @(negedge clk) begin
        if (rst_n && rd_ack) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: got err=%0d data=%h, no response expected",
                         rd_err, rd_data[W-1:0]);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({rd_err, rd_data[W-1:0]} !== e) begin
                    n_fail++;
                    $display("FAIL rd_resp: got err=%0d data=%h, expected err=%0d data=%h",
                             rd_err, rd_data[W-1:0], e[W], e[W-1:0]);
                end
            end
`ifdef DISCR_SCALER_RD_TIMESTAMP_EN
            ts_log.push_back(rd_data[DW-1:W]);
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus, then all inputs back to idle.
    task automatic drive(input logic upd, input logic [NW-1:0] cnt, input logic vld,
                         input logic req, input logic fl);
        in_update = upd;
        in_count  = cnt;
        in_valid  = vld;
        rd_req    = req;
        flush     = fl;
        tick();
        in_update = 1'b0;
        in_count  = '0;
        in_valid  = 1'b0;
        rd_req    = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic upd(input logic [NW-1:0] cnt, input logic vld);
        drive(1'b1, cnt, vld, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic err, input logic [W-1:0] data);
        exp_q.push_back({err, data});
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_ack"}, 32'(rd_ack), 0);
        chk({tag, "_rd_data"}, 32'(rd_data[W-1:0]), 0);
        chk({tag, "_rd_err"}, 32'(rd_err), 0);
        chk({tag, "_fill"}, 32'(fill), 0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_update = 1'b0; in_count = '0; in_valid = 1'b0;
        flush = 1'b0; rd_req = 1'b0;
        tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic capture: seq 0, count 4.
        upd(4'd4, 1'b1);
        chk("fill_after_write", 32'(fill), 1);
        rd(1'b0, 13'h004);
        chk("fill_after_read", 32'(fill), 0);
        tick();

        // Saturation flag: seq 1, sat=1, count F.
        upd(4'hF, 1'b0);
        rd(1'b0, 13'h03F);
        tick();

        // Full and drop from a fresh reset: seq 0..3 stored, seq 4,5 dropped.
        do_reset();
        for (int i = 0; i < 6; i++) upd(4'(i), 1'b1);
        chk("fill_full", 32'(fill), 4);
        chk("drop_cnt_2", 32'(drop_cnt), 2);

        // Write and read together at full: seq 6 stored, seq 0 popped.
        exp_q.push_back({1'b0, 13'h000});
        drive(1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        chk("fill_full_wr_rd", 32'(fill), 4);
        chk("drop_cnt_full_wr_rd", 32'(drop_cnt), 2);
        rd(1'b0, 13'h021);
        rd(1'b0, 13'h042);
        rd(1'b0, 13'h063);
        rd(1'b0, 13'h0C9);
        chk("fill_drained", 32'(fill), 0);

        // Empty read errors; write+read at empty stores without fall-through.
        rd(1'b1, 13'h000);
        exp_q.push_back({1'b1, 13'h000});
        drive(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        chk("fill_empty_wr_rd", 32'(fill), 1);
        rd(1'b0, 13'h0E5);
        chk("fill_after_e5", 32'(fill), 0);

        // Flush with a concurrent update and read: seq 8..10 stored, seq 11 lost.
        upd(4'd1, 1'b1);
        upd(4'd2, 1'b1);
        upd(4'd3, 1'b1);
        chk("fill_3", 32'(fill), 3);
        exp_q.push_back({1'b1, 13'h000});
        drive(1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
        chk("fill_flushed", 32'(fill), 0);
        chk("drop_cnt_flush", 32'(drop_cnt), 2);
        upd(4'd4, 1'b1);
        rd(1'b0, 13'h184);
        tick();
        tick();

        // Reset right after a read request: the ack must never be seen.
        upd(4'd3, 1'b1);
        upd(4'd3, 1'b1);
        rd_req = 1'b1;
        @(posedge clk);
        rd_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        upd(4'd6, 1'b1);
        rd(1'b0, 13'h006);
        tick();

`ifdef DISCR_SCALER_RD_TIMESTAMP_EN
        // Two updates exactly ten cycles apart.
        tick();
        ts_log.delete();
        upd(4'd1, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        upd(4'd2, 1'b1);
        rd(1'b0, 13'h021);
        rd(1'b0, 13'h042);
        tick();
        chk("ts_count", ts_log.size(), 2);
        if (ts_log.size() == 2) chk("ts_delta", ts_log[1] - ts_log[0], 10);
`endif

        tick();
        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/discr_scaler_reader.md
Name: discr_scaler_reader

Overview:
Consumer end of the discriminator scaler interface. Captures each period result (`update_out` strobe, `n_pedge_out` count, `valid` flag) from discr_scaler into a small FIFO. Each entry is tagged with a sequence number and a saturation flag. Results are returned to the register/readout side through a request/acknowledge read port. Sits between discr_scaler and the slow-control register bank, so software never misses a period between polls.

Parameters:
P_N_WIDTH, 16, width of the scaler count; must match discr_scaler P_N_WIDTH
P_ADDR_WIDTH, 4, FIFO address width; depth = 2**P_ADDR_WIDTH entries
P_SEQ_WIDTH, 8, width of the per-update sequence number

Ports:
clk  in  1  system clock, same domain as discr_scaler
rst_n  in  1  asynchronous active-low reset
in_update  in  1  one-cycle strobe from scaler update_out
in_count  in  P_N_WIDTH  scaler n_pedge_out, sampled when in_update=1
in_valid  in  1  scaler valid; 0 marks the count as saturated
flush  in  1  synchronous FIFO clear
rd_req  in  1  read request, one per cycle max
rd_ack  out  1  one-cycle strobe, one cycle after rd_req
rd_data  out  W  entry {seq, sat, count}; W = P_SEQ_WIDTH+1+P_N_WIDTH (timestamp added when feature enabled)
rd_err  out  1  qualifies rd_ack: request hit an empty FIFO
fill  out  P_ADDR_WIDTH+1  current occupancy
drop_cnt  out  16  updates lost to a full FIFO, saturating

Behaviour:
- Reset values (async on rst_n low): rd_ack=0, rd_data=0, rd_err=0, fill=0, drop_cnt=0. Write pointer, read pointer and seq are also 0. FIFO RAM contents are don't-care.
- Capture: on any cycle with in_update=1, form entry {seq, ~in_valid, in_count}.
  - seq increments modulo 2**P_SEQ_WIDTH on every in_update, whether the entry is stored or dropped. A drop therefore shows up as a sequence gap.
- Write rule: the entry is stored if fill < depth, or if fill == depth and a read is popped in the same cycle.
  - Otherwise it is dropped, and drop_cnt increments, saturating at 0xFFFF.
- Read rule: rd_req=1 with fill>0 pops the head entry. On the next cycle rd_ack=1, rd_err=0, and rd_data = popped entry.
  - rd_req=1 with fill=0: next cycle rd_ack=1, rd_err=1, rd_data=0; no pointer change.
  - Back-to-back rd_req on consecutive cycles is legal; each request gets its own ack.
- Simultaneous write and read with fill=0: the read returns the error response; the write is stored (no fall-through). fill goes to 1.
- Simultaneous write and read with 0<fill<depth: both are performed; fill is unchanged.
- fill updates in the same cycle as the write/pop edge, i.e. it is visible the cycle after the event.
- Pointers wrap modulo depth. Full/empty are derived from the extra MSB of the (P_ADDR_WIDTH+1)-bit pointers.
- flush=1 has priority over all other activity that cycle:
  - Pointers and fill go to 0, and any in_update that cycle is discarded.
  - drop_cnt and seq are NOT cleared.
  - Any rd_req that cycle returns the error response.
- Reset mid-operation: everything returns to reset values immediately; a pending rd_ack is cancelled.
- Between acks, rd_data holds its last value.

Optional Feature:
Macro DISCR_SCALER_RD_TIMESTAMP_EN.
- Defined: adds a 32-bit free-running cycle counter, reset to 0 by rst_n and wrapping at 2**32. Its value on the in_update cycle is prepended to the entry, so rd_data width becomes W+32 with the timestamp in the MSBs.
- Not defined: no counter, and rd_data width is W.
- All other behaviour is identical in both builds.

Test Plan:
- Reset and basic capture (P_N_WIDTH=4, P_ADDR_WIDTH=2): release rst_n; send in_update with in_count=4, in_valid=1; then rd_req. Required: rd_ack one cycle later, rd_data={8'd0,1'b0,4'd4}, rd_err=0, fill goes 1 then 0.
- Saturation flag: in_update with in_count=4'hF, in_valid=0. Required: read returns sat=1, count=F, seq=1.
- Full and drop: 6 updates with no reads. Required: fill=4, drop_cnt=2; reads return seq 0..3; the next update carries seq=6.
- Empty read, then simultaneous write/read at full:
  - rd_req with fill=0 returns rd_ack=1, rd_err=1, rd_data=0.
  - At fill=4, in_update and rd_req in the same cycle: entry stored, drop_cnt unchanged, fill stays 4.
- Flush and reset mid-stream:
  - With fill=3, flush plus in_update in the same cycle gives fill=0, and that update is lost (its seq is consumed, drop_cnt unchanged).
  - Assert rst_n low one cycle after rd_req: no rd_ack appears, and all outputs are 0.
- DISCR_SCALER_RD_TIMESTAMP_EN build: updates 10 cycles apart. Required: timestamps in the read entries differ by exactly 10.
